regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the datapath. It replaces the fixed 64x64, 2R/1W file.
//  - Configurable data width, depth, read-port count and write-port count.
//  - Optional hardwired-zero entry 0.
//  - Optional write-to-read bypass.
//  - Hardware clear sweep, run after reset and on request, with a ready flag.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_mp_if.sv | 17 +
 rtl/regfile_init_ctrl.sv | 40 ++++
 rtl/regfile_mp.sv | 53 +++++
 tb/tb_regfile_mp.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and packed-slice helper for the multi-port register file
package regfile_pkg;
  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write port bundle between decode/writeback and the register file
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  logic                     clr;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     ready;
  modport master (output clr, rd_addr, wr_en, wr_addr, wr_data, input rd_data, ready);
  modport slave (input clr, rd_addr, wr_en, wr_addr, wr_data, output rd_data, ready);
endinterface

// File: rtl/regfile_init_ctrl.sv
// regfile_init_ctrl: INIT/RUN state machine driving the clear sweep and ready flag
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              ready,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);
  rf_state_t         state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // The last sweep slot (cnt all ones) hands over to RUN; the counter never wraps.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == RF_INIT) begin
      cnt_nx   = (clr || cnt == '1) ? '0 : cnt + 1'b1;
      state_nx = (!clr && cnt == '1) ? RF_RUN : RF_INIT;
    end else if (clr) begin
      state_nx = RF_INIT;
      cnt_nx   = '0;
    end
  end
  assign ready      = state == RF_RUN;
  assign sweep_we   = state == RF_INIT;
  assign sweep_addr = cnt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with clear sweep, optional zero entry and bypass
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 6,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 0,
  parameter bit BYPASS   = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready, sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  regfile_init_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.clr),
    .ready     (ready),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr)
  );
  assign bus.ready = ready;
  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      if (!(ZERO_REG && sweep_addr == '0)) mem[sweep_addr] <= '0;
    end else if (ready) begin
      for (int j = 0; j < NUM_WR; j++)
        if (bus.wr_en[j] && !(ZERO_REG && bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == '0))
          mem[bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]] <= bus.wr_data[slice_lo(j, DATA_W) +: DATA_W];
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    assign ra = bus.rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    always_comb begin
      val = mem[ra];
      if (BYPASS)
        for (int j = 0; j < NUM_WR; j++)
          if (bus.wr_en[j] && bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == ra)
            val = bus.wr_data[slice_lo(j, DATA_W) +: DATA_W];
      if (!ready || (ZERO_REG && ra == '0)) val = '0;
    end
    assign bus.rd_data[slice_lo(i, DATA_W) +: DATA_W] = val;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp against an array-based reference model
module tb_regfile_mp;
  localparam int DW = 64, AW = 6, NR = 2, NW = 2, DEPTH = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic          clr;
  logic [AW-1:0] ra [NR];
  logic [NW-1:0] we;
  logic [AW-1:0] wa [NW];
  logic [DW-1:0] wd [NW];
  assign bus.clr     = clr;
  assign bus.rd_addr = {ra[1], ra[0]};
  assign bus.wr_en   = we;
  assign bus.wr_addr = {wa[1], wa[0]};
  assign bus.wr_data = {wd[1], wd[0]};

  typedef struct {
    string         name;
    int            kind;
    logic [DW-1:0] exp;
  } exp_t;
  exp_t q[$];

  logic [DW-1:0] mem_m [DEPTH];
  int init_left;
  int n_vec = 0;
  int n_err = 0;

  task automatic start_init();
    init_left = DEPTH;
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
  endtask

  function automatic logic model_ready();
    return rst_n && init_left == 0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(int i);
    logic [DW-1:0] v;
    if (!model_ready() || ra[i] == 0) return '0;
    v = mem_m[ra[i]];
    for (int j = 0; j < NW; j++) if (we[j] && wa[j] == ra[i]) v = wd[j];
    return v;
  endfunction

  task automatic push_const(string name, int kind, logic [DW-1:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic model_edge();
    if (!rst_n) start_init();
    else if (init_left > 0) begin
      if (clr) start_init();
      else init_left--;
    end else if (clr) start_init();
    else for (int j = 0; j < NW; j++) if (we[j] && wa[j] != 0) mem_m[wa[j]] = wd[j];
  endtask

  task automatic step(string tag);
    push_const({tag, ".ready"}, 0, DW'(model_ready()));
    for (int i = 0; i < NR; i++) push_const($sformatf("%s.rd%0d", tag, i), i + 1, exp_rd(i));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_ports(int amax);
    for (int i = 0; i < NR; i++) ra[i] = AW'($urandom_range(0, amax));
    for (int j = 0; j < NW; j++) begin
      wa[j] = AW'($urandom_range(0, amax));
      wd[j] = {$urandom(), $urandom()};
    end
    we = NW'($urandom());
  endtask

  task automatic read_all(string tag);
    we = '0;
    for (int k = 0; k < DEPTH; k += 2) begin
      ra[0] = AW'(k);
      ra[1] = AW'(k + 1);
      push_const({tag, ".zero"}, 1, '0);
      push_const({tag, ".zero"}, 2, '0);
      step(tag);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [DW-1:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      act = (e.kind == 0) ? DW'(bus.ready) : bus.rd_data[(e.kind - 1) * DW +: DW];
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    int w;
    clr = 1'b0;
    we  = '0;
    for (int i = 0; i < NR; i++) ra[i] = '0;
    for (int j = 0; j < NW; j++) begin
      wa[j] = '0;
      wd[j] = '0;
    end
    start_init();
    @(posedge clk);
    #1;
    repeat (3) step("rst");
    n_vec++;
    if (bus.ready !== 1'b0 || bus.rd_data !== '0) begin
      n_err++;
      $display("FAIL rst.state: ready=%b rd_data=%h", bus.ready, bus.rd_data);
    end
    rst_n = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      randomize_ports(DEPTH - 1);
      push_const("sweep.not_ready", 0, '0);
      step("sweep");
    end
    push_const("sweep.ready_after_64", 0, 64'd1);
    read_all("sweep_rd");

    we = 2'b01; wa[0] = 6'd5; wd[0] = 64'hDEAD_BEEF_0123_4567;
    step("t2w");
    we = '0; ra[0] = 6'd5; ra[1] = 6'd6;
    push_const("t2.readback", 1, 64'hDEAD_BEEF_0123_4567);
    push_const("t2.other", 2, '0);
    step("t2r");

    we = 2'b01; wa[0] = 6'd9; wd[0] = 64'hA5; ra[0] = 6'd9;
    push_const("t3.bypass", 1, 64'hA5);
    step("t3b");
    wa[0] = 6'd0; wd[0] = 64'hFF; ra[0] = 6'd0; ra[1] = 6'd0;
    push_const("t3.zero_bypass", 1, '0);
    step("t3z");
    we = '0;
    push_const("t3.zero_after", 2, '0);
    step("t3z2");

    we = 2'b11; wa[0] = 6'd12; wa[1] = 6'd12; wd[0] = 64'h1; wd[1] = 64'h2;
    step("t4w");
    we = '0; ra[0] = 6'd12;
    push_const("t4.collision", 1, 64'h2);
    step("t4r");

    for (int c = 0; c < 400; c++) begin
      randomize_ports(15);
      clr = ($urandom_range(0, 149) == 0);
      step("rand");
    end
    clr = 1'b0;
    for (int c = 0; c < 70; c++) begin
      randomize_ports(15);
      step("rand_tail");
    end

    clr = 1'b1; we = '0;
    push_const("t5.ready_before_clr", 0, 64'd1);
    step("t5clr");
    clr = 1'b0;
    we = 2'b01; wa[0] = 6'd3; wd[0] = 64'h1234_5678_9ABC_DEF0; ra[0] = 6'd3;
    push_const("t5.ready_fell", 0, '0);
    step("t5w");
    we = '0;
    repeat (DEPTH - 1) step("t5sweep");
    push_const("t5.ready_back", 0, 64'd1);
    read_all("t5_rd");

    clr = 1'b1;
    step("t5clr2");
    clr = 1'b0;
    repeat (30) step("t5pre");
    rst_n = 1'b0;
    start_init();
    push_const("t5.rst_drop", 0, '0);
    step("t5rst");
    rst_n = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      randomize_ports(DEPTH - 1);
      push_const("t5.restart_not_ready", 0, '0);
      step("t5re");
    end
    push_const("t5.restart_ready", 0, 64'd1);
    read_all("t5_rd2");

    w = 0;
    while (bus.ready !== 1'b1 && w < DEPTH + 2) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_vec++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL wait.ready: timed out after %0d cycles", w);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
